axi_stream_packer: RTL
======================

Name: axi_stream_packer

Overview:
- Stage directly upstream of the AXI writer.
- Accepts a write request {addr, length} plus a stream of variable-width data chunks (1–4 bytes each). Forwards the request to the writer, then packs the chunks densely, LSB-first, into 32-bit AXI-stream beats with correct tkeep/tstr/tlast.
- Waits for the writer's completion before taking the next request.

Parameters:
- ADDR_W, 16, request address width.
- LEN_W, 16, request length width in bytes.
- STREAM_ID, 0, constant driven on tid (4 bits).
- STREAM_DEST, 0, constant driven on tdest (4 bits).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous assert, active-low
- req_data  in  32  {addr[31:16], length[15:0]}
- req_vld  in  1  request valid
- req_rdy  out  1  request ready
- in_data  in  32  chunk bytes; byte i at [8i+7:8i]
- in_len  in  3  valid byte count of chunk, 0..4
- in_vld  in  1  chunk valid
- in_rdy  out  1  chunk ready
- wr_req_data  out  32  request forwarded to writer
- wr_req_vld  out  1
- wr_req_rdy  in  1
- st_tdata  out  32
- st_tstr  out  4
- st_tkeep  out  4
- st_tlast  out  1
- st_tid  out  4
- st_tdest  out  4
- st_tvalid  out  1
- st_tready  in  1
- wr_resp_data  in  1  writer status (0 = OKAY, 1 = ERROR)
- wr_resp_vld  in  1
- wr_resp_rdy  out  1
- resp_data  out  1  status returned to client
- resp_vld  out  1
- resp_rdy  in  1

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous, active-low. Async assert, sync deassert is handled externally.
- Reset values: all vld/rdy outputs 0; all data outputs 0; st_tid=STREAM_ID; st_tdest=STREAM_DEST. State IDLE, buffer count 0, bytes_left 0.
- Reset mid-operation drops any partial beat and the outstanding request without emitting tlast.
- Handshake rules: a transfer occurs on vld&rdy at a clock edge. All outputs are registered. A vld, once asserted, holds with stable data until the matching rdy.
- State machine:
  - IDLE: req_rdy=1. On req accept → latch the request, set bytes_left=length, go to REQ.
  - REQ: wr_req_vld=1, wr_req_data = latched request. On wr_req_rdy → DATA, or WAIT_RESP if length==0.
  - DATA: packing is active (rules below). When the tlast beat handshakes → WAIT_RESP.
  - WAIT_RESP: wr_resp_rdy=1. On wr_resp accept → latch status, go to RESP.
  - RESP: resp_vld=1, resp_data = latched status. On resp_rdy → IDLE.
  - Latency: request accepted at edge N gives wr_req_vld=1 from cycle N+1.
- Packing buffer: 8 bytes, byte count cnt in 0..8.
  - in_rdy = (state==DATA) && cnt<=4 && bytes_left>0.
  - On chunk accept, take = min(in_len, bytes_left). Append bytes [0..take-1] at position cnt. bytes_left -= take. Excess bytes are discarded and set sticky err_trunc, which is ORed into resp_data.
  - in_len 0 is accepted and has no effect. in_len 5..7 is treated as 4.
- Beat emission: st_tvalid asserts when cnt>=4, or when cnt>0 && bytes_left==0.
  - tdata = buffer bytes 0..3.
  - tkeep = tstr = (1<<min(cnt,4))-1. Invalid bytes are driven 0.
  - tlast = (bytes_left==0 && cnt<=4).
  - On handshake, the buffer shifts down 4 bytes and cnt -= min(cnt,4).
- Simultaneous events:
  - Accept and emit in the same cycle: shift first, then append at the post-shift cnt.
  - cnt==4 with output stalled and a chunk arriving is legal; cnt reaches 8.
  - Never accept when cnt>4.
- Arithmetic: bytes_left is LEN_W bits and never underflows (take ≤ bytes_left). cnt is 4 bits.

Decomposition:
- Package axi_stream_packer_pkg holds:
  - state enum {IDLE, REQ, DATA, WAIT_RESP, RESP}
  - request struct {addr, length}
  - constants BEAT_BYTES=4, BUF_BYTES=8
- Sub-module byte_packer_buf: 8-byte buffer with append/shift/cnt logic. The FSM stays in the top level.

Test Plan:
- Length 8, chunks of 4 and 4 → one wr_req {addr,8}; beats 2, tkeep 0xF/0xF, tlast on beat 2; resp 0 after wr_resp 0.
- Length 7, chunks of 3,3,1 carrying bytes 0x01..0x07 → beat1 tdata 0x04030201 tkeep 0xF; beat2 tdata 0x00070605 tkeep 0x7 tlast 1.
- Length 5, chunk of 4 then chunk of 4 → second chunk truncated to 1 byte; beat2 tkeep 0x1 tlast; resp_data 1 even though wr_resp_data 0.
- Length 0 → wr_req forwarded, no stream beat, in_rdy never 1, resp follows wr_resp.
- Length 16, st_tready held 0 for 10 cycles with chunks of 4 → cnt peaks at 8, in_rdy drops; after release, 4 beats in order with no loss.
- rst_n pulsed low in DATA with cnt=3 → all vld outputs 0 asynchronously; next request starts clean with cnt 0.

Source files
------------

// File: rtl/axi_stream_packer_pkg.sv
// rtl/axi_stream_packer_pkg.sv - shared types and constants for the stream packer
package axi_stream_packer_pkg;

    localparam int BEAT_BYTES = 4;
    localparam int BUF_BYTES  = 8;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        DATA,
        WAIT_RESP,
        RESP
    } state_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] length;
    } req_t;

endpackage

// File: rtl/axi_stream_packer_buf.sv
// rtl/axi_stream_packer_buf.sv - 8-byte packing buffer (byte_packer_buf) with append/shift
module byte_packer_buf
    import axi_stream_packer_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic [2:0]  push_len,
    input  logic        pop,
    output logic [3:0]  cnt_next,
    output logic [31:0] head_data,
    output logic [3:0]  head_keep
);

    logic [BUF_BYTES*8-1:0] buf_q;
    logic [BUF_BYTES*8-1:0] buf_d;
    logic [BUF_BYTES*8-1:0] shifted;
    logic [3:0]             cnt_q;
    logic [3:0]             cnt_sh;
    logic [31:0]            mask;
    logic [3:0]             keep_d;

    // Bytes above cnt are kept zero, so the head word needs no extra masking.
    always_comb begin
        mask = '0;
        for (int i = 0; i < BEAT_BYTES; i++) begin
            if (3'(i) < push_len) mask[8*i +: 8] = 8'hFF;
        end
        shifted = buf_q;
        cnt_sh  = cnt_q;
        if (pop) begin
            shifted = {32'b0, buf_q[63:32]};
            cnt_sh  = (cnt_q >= 4'd4) ? cnt_q - 4'd4 : 4'd0;
        end
        buf_d    = shifted;
        cnt_next = cnt_sh;
        if (push) begin
            buf_d    = shifted | ({32'b0, push_data & mask} << {cnt_sh, 3'b000});
            cnt_next = cnt_sh + {1'b0, push_len};
        end
        keep_d = (cnt_next >= 4'd4) ? 4'hF : (4'b0001 << cnt_next[1:0]) - 4'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q     <= '0;
            cnt_q     <= '0;
            head_keep <= '0;
        end else begin
            buf_q     <= buf_d;
            cnt_q     <= cnt_next;
            head_keep <= keep_d;
        end
    end

    assign head_data = buf_q[31:0];

endmodule

// File: rtl/axi_stream_packer.sv
// rtl/axi_stream_packer.sv - request forwarding and dense byte packing into 32-bit stream beats
module axi_stream_packer
    import axi_stream_packer_pkg::*;
#(
    parameter int         ADDR_W      = 16,
    parameter int         LEN_W       = 16,
    parameter logic [3:0] STREAM_ID   = 4'h0,
    parameter logic [3:0] STREAM_DEST = 4'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] req_data,
    input  logic        req_vld,
    output logic        req_rdy,
    input  logic [31:0] in_data,
    input  logic [2:0]  in_len,
    input  logic        in_vld,
    output logic        in_rdy,
    output logic [31:0] wr_req_data,
    output logic        wr_req_vld,
    input  logic        wr_req_rdy,
    output logic [31:0] st_tdata,
    output logic [3:0]  st_tstr,
    output logic [3:0]  st_tkeep,
    output logic        st_tlast,
    output logic [3:0]  st_tid,
    output logic [3:0]  st_tdest,
    output logic        st_tvalid,
    input  logic        st_tready,
    input  logic        wr_resp_data,
    input  logic        wr_resp_vld,
    output logic        wr_resp_rdy,
    output logic        resp_data,
    output logic        resp_vld,
    input  logic        resp_rdy
);

    state_t             state;
    state_t             state_d;
    req_t               req_in;
    logic [ADDR_W-1:0]  addr_q;
    logic [LEN_W-1:0]   length_q;
    logic [LEN_W-1:0]   bytes_left;
    logic [LEN_W-1:0]   bytes_left_d;
    logic               err_trunc;
    logic [2:0]         eff_len;
    logic [2:0]         take;
    logic               push;
    logic               pop;
    logic [3:0]         cnt_next;
    logic [3:0]         head_keep;

    assign req_in      = req_t'(req_data);
    assign wr_req_data = {16'(addr_q), 16'(length_q)};
    assign st_tid      = STREAM_ID;
    assign st_tdest    = STREAM_DEST;
    assign st_tkeep    = head_keep;
    assign st_tstr     = head_keep;

    always_comb begin
        eff_len = (in_len > 3'd4) ? 3'd4 : in_len;
        take    = eff_len;
        if (LEN_W'(eff_len) > bytes_left) take = bytes_left[2:0];
        push         = in_vld && in_rdy;
        pop          = st_tvalid && st_tready;
        state_d      = state;
        bytes_left_d = push ? bytes_left - LEN_W'(take) : bytes_left;
        case (state)
            IDLE: if (req_vld && req_rdy) begin
                state_d      = REQ;
                bytes_left_d = LEN_W'(req_in.length);
            end
            REQ:       if (wr_req_vld && wr_req_rdy) state_d = (length_q == '0) ? WAIT_RESP : DATA;
            DATA:      if (pop && st_tlast) state_d = WAIT_RESP;
            WAIT_RESP: if (wr_resp_vld && wr_resp_rdy) state_d = RESP;
            RESP:      if (resp_vld && resp_rdy) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    byte_packer_buf u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (in_data),
        .push_len  (take),
        .pop       (pop),
        .cnt_next  (cnt_next),
        .head_data (st_tdata),
        .head_keep (head_keep)
    );

    // Handshake outputs are registered from the next-state view so they line up with the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            addr_q      <= '0;
            length_q    <= '0;
            bytes_left  <= '0;
            err_trunc   <= 1'b0;
            req_rdy     <= 1'b0;
            wr_req_vld  <= 1'b0;
            in_rdy      <= 1'b0;
            st_tvalid   <= 1'b0;
            st_tlast    <= 1'b0;
            wr_resp_rdy <= 1'b0;
            resp_vld    <= 1'b0;
            resp_data   <= 1'b0;
        end else begin
            state      <= state_d;
            bytes_left <= bytes_left_d;
            if (state == IDLE && req_vld && req_rdy) begin
                addr_q    <= ADDR_W'(req_in.addr);
                length_q  <= LEN_W'(req_in.length);
                err_trunc <= 1'b0;
            end else if (push && eff_len > take) begin
                err_trunc <= 1'b1;
            end
            if (wr_resp_vld && wr_resp_rdy) resp_data <= wr_resp_data | err_trunc;
            req_rdy     <= (state_d == IDLE);
            wr_req_vld  <= (state_d == REQ);
            wr_resp_rdy <= (state_d == WAIT_RESP);
            resp_vld    <= (state_d == RESP);
            in_rdy      <= (state_d == DATA) && (cnt_next <= 4'd4) && (bytes_left_d != '0);
            st_tvalid   <= (state_d == DATA) &&
                           ((cnt_next >= 4'd4) || (cnt_next != 4'd0 && bytes_left_d == '0));
            st_tlast    <= (state_d == DATA) && (bytes_left_d == '0) &&
                           (cnt_next != 4'd0) && (cnt_next <= 4'd4);
        end
    end

endmodule
